// File: rtl/qnet_cmd_tx.sv
// qnet_cmd_tx: arbitrates local/network command requests and serialises each into a
// 2-beat AXI-Stream packet with a per-command ack. Optional counters: QNET_TX_STATS_EN.
module qnet_cmd_tx #(
  parameter int unsigned TOUT_CYC = 1024,
  parameter int unsigned TOUT_W   = 11
) (
  input  logic             t_clk_i,
  input  logic             t_rst_i,
  input  logic             channel_up_i,
  input  logic             loc_cmd_req_i,
  input  logic             net_cmd_req_i,
  input  logic [63:0]      header_i,
  input  logic [1:0][31:0] data_i,
  output logic             loc_cmd_ack_o,
  output logic             net_cmd_ack_o,
  output logic [63:0]      m_axis_tdata_o,
  output logic             m_axis_tvalid_o,
  output logic             m_axis_tlast_o,
  input  logic             m_axis_tready_i,
  output logic             busy_o,
  output logic             tout_o,
  input  logic             tout_clr_i,
  output logic [31:0]      pkt_cnt_o,
  output logic [15:0]      drop_cnt_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DAT, ST_ACK, ST_REL} state_e;
  typedef enum logic {SRC_LOC, SRC_NET} src_e;

  localparam logic [TOUT_W-1:0] TOUT_MAX = TOUT_W'(TOUT_CYC);

  state_e            state_q, state_d;
  src_e              grant_q, grant_d, last_q, last_d;
  logic [63:0]       hdr_q, hdr_d, dat_q, dat_d;
  logic [TOUT_W-1:0] stall_q, stall_d;
  logic              tout_q, tout_d;
  logic              pkt_evt, drop_evt;
  logic              granted_req, other_req, stalled, tout_set;

  assign granted_req = (grant_q == SRC_LOC) ? loc_cmd_req_i : net_cmd_req_i;
  assign other_req   = (grant_q == SRC_LOC) ? net_cmd_req_i : loc_cmd_req_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    hdr_d    = hdr_q;
    dat_d    = dat_q;
    pkt_evt  = 1'b0;
    drop_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (loc_cmd_req_i || net_cmd_req_i) begin
          if (loc_cmd_req_i && net_cmd_req_i)
            grant_d = (last_q == SRC_NET) ? SRC_LOC : SRC_NET;
          else
            grant_d = loc_cmd_req_i ? SRC_LOC : SRC_NET;
          hdr_d = header_i;
          dat_d = data_i;
          if (channel_up_i) begin
            state_d = ST_HDR;
          end else begin
            drop_evt = 1'b1;
            state_d  = ST_ACK;
          end
        end
      end
      // A link loss abandons the packet even if the beat handshakes this cycle.
      ST_HDR: begin
        if (!channel_up_i) begin
          drop_evt = 1'b1;
          state_d  = ST_ACK;
        end else if (m_axis_tready_i) begin
          state_d = ST_DAT;
        end
      end
      ST_DAT: begin
        if (!channel_up_i) begin
          drop_evt = 1'b1;
          state_d  = ST_ACK;
        end else if (m_axis_tready_i) begin
          pkt_evt = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        last_d  = grant_q;
        state_d = ST_REL;
      end
      // Leave early when the other source waits, so two held requests alternate.
      ST_REL: begin
        if (!granted_req || other_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stalled = m_axis_tvalid_o && !m_axis_tready_i;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE || (m_axis_tvalid_o && m_axis_tready_i))
      stall_d = '0;
    else if (stalled && stall_q != TOUT_MAX)
      stall_d = stall_q + 1'b1;
    tout_set = stalled && (stall_d == TOUT_MAX);
    tout_d   = tout_q;
    if (tout_set)        tout_d = 1'b1;
    else if (tout_clr_i) tout_d = 1'b0;
  end

  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= SRC_LOC;
      last_q  <= SRC_NET;
      hdr_q   <= '0;
      dat_q   <= '0;
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hdr_q   <= hdr_d;
      dat_q   <= dat_d;
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end

  assign m_axis_tvalid_o = (state_q == ST_HDR) || (state_q == ST_DAT);
  assign m_axis_tlast_o  = (state_q == ST_DAT);
  assign m_axis_tdata_o  = (state_q == ST_HDR) ? hdr_q :
                           (state_q == ST_DAT) ? dat_q : 64'd0;
  assign loc_cmd_ack_o   = (state_q == ST_ACK) && (grant_q == SRC_LOC);
  assign net_cmd_ack_o   = (state_q == ST_ACK) && (grant_q == SRC_NET);
  assign busy_o          = (state_q != ST_IDLE);
  assign tout_o          = tout_q;

`ifdef QNET_TX_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q  + (pkt_evt  ? 32'd1 : 32'd0);
    drop_cnt_d = drop_cnt_q + (drop_evt ? 16'd1 : 16'd0);
  end

  always_ff @(posedge t_clk_i or posedge t_rst_i) begin
    if (t_rst_i) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = pkt_evt ^ drop_evt;
  assign pkt_cnt_o    = 32'd0;
  assign drop_cnt_o   = 16'd0;
`endif

endmodule

// File: tb/tb_qnet_cmd_tx.sv
// Directed self-checking bench for qnet_cmd_tx (stall timeout shortened to 16 cycles).
module tb_qnet_cmd_tx;

  localparam int TOUT_CYC = 16;
  localparam int TOUT_W   = 5;
`ifdef QNET_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             t_clk = 1'b0;
  logic             t_rst = 1'b1;
  logic             channel_up = 1'b1;
  logic             loc_req = 1'b0, net_req = 1'b0;
  logic [63:0]      header = '0;
  logic [1:0][31:0] data = '0;
  logic             loc_ack, net_ack;
  logic [63:0]      tdata;
  logic             tvalid, tlast;
  logic             tready = 1'b1;
  logic             busy, tout;
  logic             tout_clr = 1'b0;
  logic [31:0]      pkt_cnt;
  logic [15:0]      drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int loc_acks = 0, net_acks = 0, both_acks = 0;
  byte ack_seq[$];

  qnet_cmd_tx #(.TOUT_CYC(TOUT_CYC), .TOUT_W(TOUT_W)) dut (
    .t_clk_i(t_clk), .t_rst_i(t_rst), .channel_up_i(channel_up),
    .loc_cmd_req_i(loc_req), .net_cmd_req_i(net_req),
    .header_i(header), .data_i(data),
    .loc_cmd_ack_o(loc_ack), .net_cmd_ack_o(net_ack),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tlast_o(tlast),
    .m_axis_tready_i(tready), .busy_o(busy), .tout_o(tout), .tout_clr_i(tout_clr),
    .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 t_clk = ~t_clk;

  // Acks are registered-state outputs; sample them mid-cycle.
  always @(negedge t_clk) begin
    if (loc_ack) begin loc_acks++; ack_seq.push_back(8'd0); end
    if (net_ack) begin net_acks++; ack_seq.push_back(8'd1); end
    if (loc_ack && net_ack) both_acks++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic do_reset();
    t_rst = 1'b1;
    loc_req = 1'b0; net_req = 1'b0; tout_clr = 1'b0;
    channel_up = 1'b1; tready = 1'b1;
    repeat (2) @(posedge t_clk);
    #1 t_rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, na, sb, errs;

    // Reset state
    do_reset();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_acks", 64'({loc_ack, net_ack}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tout", 64'(tout), 64'd0);
    check("rst_cnts", {pkt_cnt, 16'd0, drop_cnt}, 64'd0);

    // Single local command; inputs change after grant to prove capture
    la = loc_acks; na = net_acks;
    header = 64'h8100_0000_0000_0001;
    data[1] = 32'h0000_BBBB; data[0] = 32'h0000_AAAA;
    loc_req = 1'b1;
    tick();
    check("t1_hdr_valid", 64'(tvalid), 64'd1);
    check("t1_hdr_data", tdata, 64'h8100_0000_0000_0001);
    check("t1_hdr_last", 64'(tlast), 64'd0);
    header = '1; data = {32'h5555_5555, 32'h5555_5555};
    tick();
    check("t1_dat_data", tdata, 64'h0000BBBB_0000AAAA);
    check("t1_dat_last", 64'(tlast), 64'd1);
    tick();
    check("t1_ack", 64'({loc_ack, net_ack, tvalid}), 64'b100);
    check("t1_pkt", 64'(pkt_cnt), sx(1));
    loc_req = 1'b0;
    wait_idle("t1");
    check("t1_ack_count", 64'(loc_acks - la), 64'd1);
    check("t1_net_ack_count", 64'(net_acks - na), 64'd0);

    // Simultaneous held requests: LOC first, then strict alternation
    do_reset();
    sb = ack_seq.size(); la = both_acks;
    loc_req = 1'b1; net_req = 1'b1;
    for (int i = 0; i < 60 && (ack_seq.size() - sb) < 4; i++) tick();
    loc_req = 1'b0; net_req = 1'b0;
    wait_idle("t2");
    check("t2_n_acks", 64'(ack_seq.size() - sb), 64'd4);
    if (ack_seq.size() - sb >= 4) begin
      check("t2_first_loc", 64'(ack_seq[sb]), 64'd0);
      check("t2_then_net", 64'(ack_seq[sb+1]), 64'd1);
      check("t2_then_loc", 64'(ack_seq[sb+2]), 64'd0);
      check("t2_then_net2", 64'(ack_seq[sb+3]), 64'd1);
    end
    check("t2_never_both", 64'(both_acks - la), 64'd0);
    check("t2_pkt", 64'(pkt_cnt), sx(4));

    // Backpressure on the data beat for 10 cycles
    do_reset();
    na = net_acks;
    header = 64'h0123_4567_89AB_CDEF;
    data[1] = 32'hCAFE_F00D; data[0] = 32'h1234_5678;
    net_req = 1'b1;
    tick();
    tick();
    tready = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== 64'hCAFE_F00D_1234_5678 || net_ack !== 1'b0)
        errs++;
    end
    check("t3_stable", 64'(errs), 64'd0);
    check("t3_tout_low", 64'(tout), 64'd0);
    tready = 1'b1;
    tick();
    check("t3_ack", 64'(net_ack), 64'd1);
    net_req = 1'b0;
    wait_idle("t3");
    check("t3_ack_count", 64'(net_acks - na), 64'd1);
    check("t3_tout_after", 64'(tout), 64'd0);

    // Stall timeout at 16 stalled cycles, sticky, then cleared
    do_reset();
    tready = 1'b0;
    loc_req = 1'b1;
    tick();
    repeat (15) tick();
    check("t4_tout_15", 64'(tout), 64'd0);
    tick();
    check("t4_tout_16", 64'(tout), 64'd1);
    tready = 1'b1;
    tick();
    tick();
    loc_req = 1'b0;
    wait_idle("t4");
    check("t4_sticky", 64'(tout), 64'd1);
    tout_clr = 1'b1;
    tick();
    tout_clr = 1'b0;
    check("t4_cleared", 64'(tout), 64'd0);

    // Set on the same cycle as a clear wins
    tready = 1'b0;
    loc_req = 1'b1;
    tick();
    repeat (15) tick();
    tout_clr = 1'b1;
    tick();
    check("t4_set_wins", 64'(tout), 64'd1);
    tout_clr = 1'b0;
    tready = 1'b1;
    tick();
    tick();
    loc_req = 1'b0;
    wait_idle("t4b");

    // Link down at grant: drop without a packet
    do_reset();
    channel_up = 1'b0;
    net_req = 1'b1;
    tick();
    check("t5_no_valid", 64'(tvalid), 64'd0);
    check("t5_ack", 64'(net_ack), 64'd1);
    net_req = 1'b0;
    wait_idle("t5");
    check("t5_drop", 64'(drop_cnt), sx(1));
    check("t5_pkt", 64'(pkt_cnt), 64'd0);

    // Link drop while the header beat is stalled
    do_reset();
    tready = 1'b0;
    loc_req = 1'b1;
    tick();
    check("t6_hdr_valid", 64'(tvalid), 64'd1);
    channel_up = 1'b0;
    tick();
    check("t6_valid_low", 64'(tvalid), 64'd0);
    check("t6_ack", 64'(loc_ack), 64'd1);
    loc_req = 1'b0;
    channel_up = 1'b1;
    tready = 1'b1;
    wait_idle("t6");
    check("t6_pkt", 64'(pkt_cnt), 64'd0);
    check("t6_drop", 64'(drop_cnt), sx(1));

    // Async reset mid-packet (during DAT), then during ACK after one packet
    do_reset();
    loc_req = 1'b1;
    tick();
    tick();
    #2 t_rst = 1'b1;
    #1;
    check("t7_dat_tvalid", 64'(tvalid), 64'd0);
    check("t7_dat_busy", 64'(busy), 64'd0);
    do_reset();
    loc_req = 1'b1;
    repeat (3) tick();
    check("t7_ack_pre", 64'(loc_ack), 64'd1);
    check("t7_pkt_pre", 64'(pkt_cnt), sx(1));
    #2 t_rst = 1'b1;
    #1;
    check("t7_ack_low", 64'({loc_ack, net_ack}), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_cnts", {pkt_cnt, 16'd0, drop_cnt}, 64'd0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qnet_cmd_tx.md
Name: qnet_cmd_tx

Overview:
- Sits directly downstream of the command coder, in the tnet transmit clock domain.
- Consumes the coder's level requests (loc_cmd_req / net_cmd_req) with the shared 64-bit header and 2x32-bit data.
- Arbitrates between local and network requests, serialises each command into a 2-beat AXI-Stream packet for the serial-link TX, and returns a single-cycle ack per command.
- Flags link stalls and drops commands while the link is down.

Parameters:
- TOUT_CYC, 1024: m_axis_tready_i low cycles, while tvalid is high, before tout_o sets.
- TOUT_W, 11: width of the stall counter; must satisfy 2^TOUT_W > TOUT_CYC.

Ports:
- t_clk_i  in  1  transmit clock; the only clock.
- t_rst_i  in  1  asynchronous reset, active-high.
- channel_up_i  in  1  serial link up.
- loc_cmd_req_i  in  1  local command request (level).
- net_cmd_req_i  in  1  network command request (level).
- header_i  in  64  command header.
- data_i  in  32x2  command data; [0] is the low word.
- loc_cmd_ack_o  out  1  ack pulse for a local command.
- net_cmd_ack_o  out  1  ack pulse for a network command.
- m_axis_tdata_o  out  64  TX stream data.
- m_axis_tvalid_o  out  1  TX stream valid.
- m_axis_tlast_o  out  1  TX stream last.
- m_axis_tready_i  in  1  TX stream ready.
- busy_o  out  1  FSM not in IDLE.
- tout_o  out  1  sticky stall flag.
- tout_clr_i  in  1  clears tout_o.
- pkt_cnt_o  out  32  packets sent (optional feature).
- drop_cnt_o  out  16  commands dropped (optional feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, last_grant=NET (so the first tie goes to LOC), counters 0.
- FSM states: IDLE, HDR, DAT, ACK, REL.
- IDLE:
  - If any request is high: grant.
    - Only one request high: grant that one.
    - Both high: grant the source not equal to last_grant.
  - On grant: capture header_i and {data_i[1],data_i[0]} into internal registers, record the grant.
  - If channel_up_i=1: go to HDR. If channel_up_i=0: count a drop and go to ACK.
- HDR:
  - tvalid=1, tdata=captured header, tlast=0.
  - On tready: go to DAT.
- DAT:
  - tvalid=1, tdata={data[1],data[0]}, tlast=1.
  - On tready: go to ACK; pkt_cnt+1.
- ACK:
  - One cycle; the granted source's ack=1.
  - Update last_grant; go to REL.
- REL:
  - Wait until the granted request is low, then go to IDLE.
  - This guards against re-serving a request the coder has not yet dropped.
  - If the granted request stays high for a new command from the coder, it is served after it falls and rises, or immediately if the other source is pending.
- Latency:
  - Request high in IDLE -> tvalid on the next cycle.
  - Minimum 5 cycles from grant back to IDLE with tready held high.
- AXIS rules:
  - tvalid, once high, holds with stable tdata/tlast until tready.
  - Exception: channel_up_i falling in HDR or DAT drops tvalid the next cycle, goes to ACK, and counts a drop. No pkt_cnt increment.
- Stall timeout:
  - The counter increments each cycle tvalid=1 and tready=0; it clears on any handshake or in IDLE.
  - When it reaches TOUT_CYC, tout_o=1 (sticky); the counter saturates.
  - tout_clr_i clears tout_o. A set on the same cycle as a clear wins.
- The captured header/data are not affected by header_i changing after grant.
- pkt_cnt and drop_cnt wrap around.

Optional Feature:
- Macro: QNET_TX_STATS_EN.
- Defined: pkt_cnt_o and drop_cnt_o are live registered counters.
- Undefined: the counter logic is absent and both outputs are tied to 0.
- FSM behaviour is identical in both builds.

Test Plan:
- Single local command:
  - Stimulus: header=64'h8100_0000_0000_0001, data={32'hBBBB, 32'hAAAA}, tready=1.
  - Response: beat0 = header with tlast=0; beat1 = 64'h0000BBBB_0000AAAA with tlast=1; loc_cmd_ack_o pulses exactly once; pkt_cnt=1.
- Simultaneous requests:
  - Stimulus: loc and net both high from reset and held.
  - Response: LOC is served first, then NET; the acks alternate and are never both high in one cycle.
- Backpressure on the data beat:
  - Stimulus: tready=0 for 10 cycles during DAT.
  - Response: tvalid, tdata and tlast are stable for those 10 cycles; exactly 1 ack; tout_o stays 0.
- Stall timeout and clear:
  - Stimulus: TOUT_CYC=16, tready held 0.
  - Response: tout_o rises on the 16th stalled cycle and stays high after tready=1; tout_clr_i pulse -> 0.
- Link down:
  - Stimulus: net request with channel_up_i=0.
  - Response: no tvalid; net_cmd_ack_o pulses; drop_cnt=1.
- Link drop mid-packet:
  - Stimulus: channel_up_i falls during HDR.
  - Response: tvalid low the next cycle; ack issued; pkt_cnt unchanged; drop_cnt+1.
- Async reset mid-packet:
  - Stimulus: assert t_rst_i mid-packet.
  - Response: tvalid and acks go low immediately, FSM returns to IDLE, counters read 0.
